// File: rtl/accumulator_drain_if.sv
// Valid/ready result stream carried from accumulator_drain to its consumer.
interface accumulator_drain_if #(
  parameter int OUT_WIDTH = 8,
  parameter int IDX_WIDTH = 4
);
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic [IDX_WIDTH-1:0] out_idx;
  logic                 out_last;
  logic                 out_sat;

  modport master (
    output out_valid, out_data, out_idx, out_last, out_sat,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_idx, out_last, out_sat,
    output out_ready
  );
endinterface

// File: rtl/accumulator_drain.sv
// Snapshots all accumulator lanes on start, clears the accumulator, then
// streams the snapshot one saturated element per handshake.
module accumulator_drain #(
  parameter int NUM_ELEM  = 16,
  parameter int ACC_WIDTH = 16,
  parameter int OUT_WIDTH = 8,
  parameter int IDX_WIDTH = $clog2(NUM_ELEM)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [NUM_ELEM-1:0][ACC_WIDTH-1:0]  sum,
  output logic                                acc_clear,
  accumulator_drain_if.master                 stream,
  output logic                                busy,
  output logic                                done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                              state;
  logic [IDX_WIDTH-1:0]                idx;
  logic [NUM_ELEM-1:0][ACC_WIDTH-1:0]  shadow;

  logic                 can_start;
  logic                 in_stream;
  logic                 is_last;
  logic                 handshake;
  logic [ACC_WIDTH-1:0] cur;
  logic                 cur_sat;

  assign can_start = (state == IDLE) || (state == DONE);
  assign in_stream = (state == STREAM);
  assign is_last   = (idx == IDX_WIDTH'(NUM_ELEM - 1));
  assign handshake = in_stream && stream.out_ready;

  // The accumulator clears on the same edge that loads the shadow bank.
  assign acc_clear = start && can_start && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      shadow <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            shadow <= sum;
            idx    <= '0;
            state  <= STREAM;
          end else begin
            state  <= IDLE;
          end
        end
        STREAM: begin
          if (handshake) begin
            if (is_last) begin
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Any bit above the output width means the value exceeds all-ones.
  assign cur     = shadow[idx];
  assign cur_sat = |(cur >> OUT_WIDTH);

  assign stream.out_valid = in_stream;
  assign stream.out_data  = !in_stream ? '0 :
                            cur_sat    ? {OUT_WIDTH{1'b1}} : cur[OUT_WIDTH-1:0];
  assign stream.out_idx   = in_stream ? idx : '0;
  assign stream.out_last  = in_stream && is_last;
  assign stream.out_sat   = in_stream && cur_sat;

  assign busy = in_stream;
  assign done = (state == DONE);

endmodule

// File: tb/tb_accumulator_drain.sv
// Directed bench for accumulator_drain with four lanes, 16-bit sums, 8-bit output.
module tb_accumulator_drain;
  localparam int NE = 4;
  localparam int AW = 16;
  localparam int OW = 8;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [NE-1:0][AW-1:0] sum;
  logic              acc_clear;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  accumulator_drain_if #(.OUT_WIDTH(OW), .IDX_WIDTH(IW)) bus ();

  accumulator_drain #(
    .NUM_ELEM (NE),
    .ACC_WIDTH(AW),
    .OUT_WIDTH(OW),
    .IDX_WIDTH(IW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sum      (sum),
    .acc_clear(acc_clear),
    .stream   (bus.master),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sum(input int a, input int b, input int c, input int d);
    sum[0] = AW'(a);
    sum[1] = AW'(b);
    sum[2] = AW'(c);
    sum[3] = AW'(d);
  endtask

  task automatic chk_beat(input string tag, input int valid, input int data,
                          input int idx, input int last, input int sat);
    chk({tag, ".valid"}, int'(bus.out_valid), valid);
    chk({tag, ".data"},  int'(bus.out_data),  data);
    chk({tag, ".idx"},   int'(bus.out_idx),   idx);
    chk({tag, ".last"},  int'(bus.out_last),  last);
    chk({tag, ".sat"},   int'(bus.out_sat),   sat);
    chk({tag, ".busy"},  int'(busy),          valid);
  endtask

  task automatic chk_idle(input string tag);
    chk_beat(tag, 0, 0, 0, 0, 0);
    chk({tag, ".done"},  int'(done),      0);
    chk({tag, ".clear"}, int'(acc_clear), 0);
  endtask

  // Drains four beats with ready high; start must already have been sampled.
  task automatic drain(input string tag, input int d0, input int d1, input int d2,
                       input int d3, input int sat_mask);
    int d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_beat($sformatf("%s.b%0d", tag, i), 1, d[i], i, (i == 3) ? 1 : 0,
               (sat_mask >> i) & 1);
      chk($sformatf("%s.b%0d.clear", tag, i), int'(acc_clear), 0);
      chk($sformatf("%s.b%0d.done", tag, i), int'(done), 0);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    bus.out_ready = 1'b1;
    set_sum(100, 200, 300, 400);
    #2;
    chk_idle("reset");
    tick();
    tick();
    chk_idle("reset.held");
    start = 1'b0;
    rst = 1'b0;
    tick();
    chk_idle("idle");

    // basic drain with saturation on lane 3
    set_sum(3, 7, 255, 256);
    start = 1'b1;
    #1;
    chk("basic.clear", int'(acc_clear), 1);
    chk("basic.pre_valid", int'(bus.out_valid), 0);
    tick();
    start = 1'b0;
    drain("basic", 3, 7, 255, 255, 4'b1000);
    chk("basic.done", int'(done), 1);
    chk_beat("basic.done_cyc", 0, 0, 0, 0, 0);
    tick();
    chk("basic.done_once", int'(done), 0);
    chk_idle("basic.after");

    // backpressure: ready toggles 0/1 starting on the first beat
    set_sum(1, 2, 3, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus.out_ready = c[0];
      #1;
      chk_beat($sformatf("bp.c%0d", c), 1, c / 2 + 1, c / 2, (c / 2 == 3) ? 1 : 0, 0);
      tick();
    end
    chk("bp.done", int'(done), 1);
    bus.out_ready = 1'b1;
    tick();

    // start ignored mid-stream and sum changes do not reach the output
    set_sum(1, 2, 3, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk_beat("iso.b0", 1, 1, 0, 0, 0);
    set_sum(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    tick();
    start = 1'b1;
    #1;
    chk("iso.clear_blocked", int'(acc_clear), 0);
    chk_beat("iso.b1", 1, 2, 1, 0, 0);
    tick();
    start = 1'b0;
    #1;
    chk_beat("iso.b2", 1, 3, 2, 0, 0);
    tick();
    chk_beat("iso.b3", 1, 4, 3, 1, 0);
    tick();
    chk("iso.done", int'(done), 1);
    tick();
    chk_idle("iso.after");

    // reset after two handshakes abandons the frame
    set_sum(5, 6, 7, 8);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_beat("rst.b0", 1, 5, 0, 0, 0);
    tick();
    chk_beat("rst.b1", 1, 6, 1, 0, 0);
    tick();
    rst = 1'b1;
    #1;
    chk_idle("rst.async");
    tick();
    chk_idle("rst.held");
    rst = 1'b0;
    tick();
    chk_idle("rst.released");

    set_sum(9, 8, 7, 6);
    start = 1'b1;
    #1;
    chk("rst.restart_clear", int'(acc_clear), 1);
    tick();
    start = 1'b0;
    drain("rst.restart", 9, 8, 7, 6, 0);

    // back-to-back: start taken in the done cycle
    chk("b2b.done", int'(done), 1);
    set_sum(10, 20, 30, 40);
    start = 1'b1;
    #1;
    chk("b2b.clear", int'(acc_clear), 1);
    tick();
    start = 1'b0;
    drain("b2b", 10, 20, 30, 40, 0);
    chk("b2b.done2", int'(done), 1);

    // saturation boundary around 255
    set_sum(0, 254, 255, 16'hFFFF);
    start = 1'b1;
    tick();
    start = 1'b0;
    drain("satb", 0, 254, 255, 255, 4'b1000);
    chk("satb.done", int'(done), 1);
    tick();
    chk_idle("satb.after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/accumulator_drain.md
# accumulator_drain

Downstream companion of the weight accumulator array. On a `start` request it snapshots all `NUM_ELEM` accumulated sums into a shadow bank and clears the accumulator in the same edge. It then streams the snapshot out one element per beat over a valid/ready interface, saturating each value to `OUT_WIDTH`. Because of the shadow bank, the accumulator can begin the next accumulation window while the previous one drains.

## Interface
Parameters:
- `NUM_ELEM`, 16: number of accumulator lanes, equal to `DIM_ROW2*DIM_COL2`.
- `ACC_WIDTH`, 16: width of each accumulated sum, equal to `ACC_WIDTH`.
- `OUT_WIDTH`, 8: width of each streamed result. Requires `OUT_WIDTH <= ACC_WIDTH`.
- `IDX_WIDTH`, `$clog2(NUM_ELEM)`: width of the element index.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  request to capture and drain the current sums.
- `sum`  in  `[NUM_ELEM][ACC_WIDTH]`  accumulator outputs, unsigned.
- `acc_clear`  out  1  clear strobe to the accumulator, combinational.
- `out_valid`  out  1  `out_data` holds a valid beat.
- `out_ready`  in  1  consumer accepts the beat.
- `out_data`  out  `OUT_WIDTH`  saturated element value.
- `out_idx`  out  `IDX_WIDTH`  element index of the current beat.
- `out_last`  out  1  current beat is element `NUM_ELEM-1`.
- `out_sat`  out  1  current beat was saturated.
- `busy`  out  1  capture taken, drain not finished.
- `done`  out  1  one-cycle pulse after the final handshake.

## Operation
- FSM states are `IDLE`, `STREAM` and `DONE`.
- **IDLE**
  - `start=1` captures `sum` into the shadow bank, sets idx to 0 and moves to `STREAM`.
  - `acc_clear = start && state==IDLE && !rst`, so the accumulator clears on the same edge as the capture.
  - Any `val` the accumulator adds in that clear cycle is lost. The upstream controller must not enable the accumulator in the `start` cycle.
- **STREAM**
  - `out_valid=1`.
  - `out_data = (shadow[idx] > 2^OUT_WIDTH-1) ? all-ones : shadow[idx][OUT_WIDTH-1:0]`.
  - `out_sat` is set when the saturation applies.
  - A beat is handshaked when `out_valid && out_ready`; each handshake increments idx.
  - The handshake with `idx==NUM_ELEM-1` moves the FSM to `DONE`.
- **DONE**
  - `done=1` for exactly one cycle, then return to `IDLE`.
  - `start` is also accepted in this cycle: it is captured, `acc_clear` fires, and the FSM moves directly to `STREAM`.
- **start in STREAM:** ignored. No capture and no `acc_clear`.
- **Snapshot isolation:** changes on `sum` after capture never affect the streamed data.
- **Backpressure:** while `out_valid && !out_ready`, `out_data`, `out_idx`, `out_last` and `out_sat` hold stable.
- **Output values outside STREAM:** `out_data`, `out_idx`, `out_last` and `out_sat` drive 0.
- **busy:** 1 in `STREAM`, 0 otherwise.

## Timing
- **Reset values:** FSM `IDLE`, idx 0, shadow bank 0. `out_valid`, `out_data`, `out_idx`, `out_last`, `out_sat`, `busy`, `done` and `acc_clear` are all 0.
- **Reset response:** reset acts immediately (asynchronous). Reset mid-stream abandons the frame with no `done` pulse.
- **Start timing:** `start` is sampled at edge T. `acc_clear` is high during the cycle before edge T. `out_valid` rises after T.
- **Throughput with `out_ready` held high:**
  - Beats occupy the `NUM_ELEM` cycles after T.
  - `done` is high in cycle `NUM_ELEM+1` after T.
  - Back-to-back frames need `NUM_ELEM+1` cycles each.
- **Beat latency:** zero added latency. `out_data` is a combinational mux plus saturation from registered idx and shadow.

## Test plan
Use `NUM_ELEM=4`, `ACC_WIDTH=16`, `OUT_WIDTH=8`.
- **Basic drain:** `sum={3,7,255,256}`, one-cycle `start`, `out_ready=1` -> beats 3,7,255,255 with idx 0..3; `out_sat` 0,0,0,1; `out_last` on beat 3 only; `acc_clear` high exactly one cycle; `done` one cycle after beat 3.
- **Backpressure:** `sum={1,2,3,4}`, `out_ready` toggling 0/1 from the first beat -> outputs held while ready is low; 4 handshakes in 8 cycles; data 1,2,3,4 in order; no duplicates.
- **Busy and isolation:** `start` pulsed again during beat 1 and `sum` changed to all `0xFFFF` during the stream -> no `acc_clear`, no restart, original data 1,2,3,4 delivered.
- **Reset mid-stream:** assert `rst` after 2 handshakes -> all outputs 0 immediately and no `done`. After release, `start` with `sum={9,8,7,6}` streams from idx 0.
- **Back-to-back:** `start` asserted in the `done` cycle with new `sum={10,20,30,40}` -> `acc_clear` fires; second frame begins the next cycle with no idle gap.
- **Saturation boundary:** `sum={0,254,255,0xFFFF}` -> 0,254,255,255 with `out_sat` 0,0,0,1.
